// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use and branch
// interlocks, and a single-entry scoreboard tracking one multi-cycle MUL/DIV.
module hazard_scoreboard_unit #(
    parameter int AW        = 5,
    parameter int MD_CYCLES = 34,
    parameter int CNT_W     = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1_d,
    input  logic [AW-1:0] rs2_d,
    input  logic [AW-1:0] rd_d,
    input  logic          regwrite_d,
    input  logic          md_op_d,
    input  logic          branch_d,
    input  logic          branch_taken_d,
    input  logic [AW-1:0] rs1_e,
    input  logic [AW-1:0] rs2_e,
    input  logic [AW-1:0] rd_e,
    input  logic          regwrite_e,
    input  logic          memtoreg_e,
    input  logic          md_start_e,
    input  logic [AW-1:0] rd_m,
    input  logic          regwrite_m,
    input  logic          memtoreg_m,
    input  logic [AW-1:0] rd_w,
    input  logic          regwrite_w,
    output logic [1:0]    fwd_a_e,
    output logic [1:0]    fwd_b_e,
    output logic          fwd_a_d,
    output logic          fwd_b_d,
    output logic          stall_f,
    output logic          stall_d,
    output logic          flush_e,
    output logic          flush_d,
    output logic          md_busy,
    output logic [AW-1:0] md_rd,
    output logic          md_wb
);

    localparam logic [AW-1:0]    ZERO_REG = '0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_md_rd;

    logic w_cnt_zero;
    logic w_start;
    logic w_lu_stall;
    logic w_br_stall;
    logic w_sb_stall;
    logic w_st_stall;
    logic w_stall;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                           input logic [AW-1:0] rdm,
                                           input logic          rwm,
                                           input logic [AW-1:0] rdw,
                                           input logic          rww);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != ZERO_REG && rs == rdm && rwm)
            sel = 2'b10;
        else if (rs != ZERO_REG && rs == rdw && rww)
            sel = 2'b01;
        return sel;
    endfunction

    function automatic logic src_hit(input logic [AW-1:0] rd,
                                     input logic [AW-1:0] a,
                                     input logic [AW-1:0] b);
        return (rd != ZERO_REG) && (rd == a || rd == b);
    endfunction

    assign fwd_a_e = fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
    assign fwd_b_e = fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
    assign fwd_a_d = (rs1_d != ZERO_REG) && (rs1_d == rd_m) && regwrite_m;
    assign fwd_b_d = (rs2_d != ZERO_REG) && (rs2_d == rd_m) && regwrite_m;

    assign w_cnt_zero = (r_cnt == '0);
    // A start in the writeback cycle reloads with no idle gap.
    assign w_start    = md_start_e && (!r_busy || w_cnt_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_md_rd <= '0;
        end else if (w_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= CNT_LOAD;
            r_md_rd <= rd_e;
        end else if (r_busy) begin
            if (!w_cnt_zero)
                r_cnt <= r_cnt - 1'b1;
            else
                r_busy <= 1'b0;
        end
    end

    assign md_busy = r_busy;
    assign md_rd   = r_md_rd;
    assign md_wb   = r_busy && w_cnt_zero;

    assign w_lu_stall = memtoreg_e && src_hit(rd_e, rs1_d, rs2_d);
    assign w_br_stall = branch_d &&
                        ((regwrite_e && src_hit(rd_e, rs1_d, rs2_d)) ||
                         (memtoreg_m && src_hit(rd_m, rs1_d, rs2_d)));
    assign w_sb_stall = r_busy && (r_md_rd != ZERO_REG) &&
                        (r_md_rd == rs1_d || r_md_rd == rs2_d ||
                         (regwrite_d && rd_d == r_md_rd));
    assign w_st_stall = md_op_d && r_busy && !w_cnt_zero;

    assign w_stall = w_lu_stall || w_br_stall || w_sb_stall || w_st_stall;
    assign stall_f = w_stall;
    assign stall_d = w_stall;
    assign flush_e = w_stall;
    assign flush_d = branch_taken_d && !w_stall;

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 SHALL have parameter AW, default 5: register-address width.
REQ-002 SHALL have parameter MD_CYCLES, default 34: multi-cycle MUL/DIV occupancy in cycles; legal range is 1 or more.
REQ-003 SHALL have parameter CNT_W, default 6: counter width, with 2**CNT_W greater than MD_CYCLES-1.
REQ-004 SHALL have ports clk in 1 (clock) and rst in 1 (synchronous, active-high reset).
REQ-005 SHALL have inputs rs1_d, rs2_d, rd_d, each AW wide: Decode source and destination registers.
REQ-006 SHALL have inputs regwrite_d, md_op_d, branch_d, branch_taken_d, each 1 bit: Decode writes rd, Decode is MUL/DIV, Decode is branch, branch resolved taken.
REQ-007 SHALL have inputs rs1_e, rs2_e, rd_e, each AW wide, and inputs regwrite_e, memtoreg_e, md_start_e, each 1 bit: Execute fields; md_start_e launches MUL/DIV.
REQ-008 SHALL have inputs rd_m (AW), regwrite_m (1), memtoreg_m (1), rd_w (AW) and regwrite_w (1): Memory and Writeback fields.
REQ-009 SHALL have outputs fwd_a_e and fwd_b_e, each 2 bits: ALU operand select, 00 = register file, 10 = Memory, 01 = Writeback.
REQ-010 SHALL have outputs fwd_a_d and fwd_b_d, each 1 bit: Decode comparator select from Memory.
REQ-011 SHALL have outputs stall_f, stall_d, flush_e, flush_d, each 1 bit.
REQ-012 SHALL have outputs md_busy (1), md_rd (AW) and md_wb (1): scoreboard state and one-cycle writeback strobe.

Function
REQ-013 SHALL set fwd_a_e to 10 when rs1_e!=0, rs1_e==rd_m and regwrite_m; otherwise to 01 when rs1_e!=0, rs1_e==rd_w and regwrite_w; otherwise to 00. Memory has priority over Writeback.
REQ-014 SHALL compute fwd_b_e identically to REQ-013 using rs2_e.
REQ-015 SHALL assert fwd_a_d when rs1_d!=0, rs1_d==rd_m and regwrite_m, and SHALL compute fwd_b_d the same way using rs2_d.
REQ-016 SHALL raise a load-use stall when memtoreg_e, rd_e!=0 and rd_e matches rs1_d or rs2_d.
REQ-017 SHALL raise a branch stall when branch_d holds and either condition below is true; register x0 never matches:
- regwrite_e and rd_e matches rs1_d or rs2_d;
- memtoreg_m and rd_m matches rs1_d or rs2_d.
REQ-018 SHALL hold scoreboard state in registers busy, cnt (CNT_W bits) and md_rd; md_busy SHALL equal busy.
REQ-019 SHALL start an operation when md_start_e is high in cycle T and busy is low, or busy is high with cnt==0. At T+1: busy=1, cnt=MD_CYCLES-1, md_rd=rd_e.
REQ-020 SHALL decrement cnt by 1 each cycle while busy and cnt!=0; cnt SHALL never wrap.
REQ-021 SHALL drive md_wb = busy AND cnt==0 combinationally, so it is high exactly in cycle T+MD_CYCLES.
REQ-022 SHALL clear busy in the cycle after md_wb unless a new start is accepted in the md_wb cycle, in which case the back-to-back reload of REQ-019 applies.
REQ-023 SHALL ignore md_start_e while busy and cnt!=0, leaving state unchanged.
REQ-024 SHALL raise a scoreboard stall while busy and md_rd!=0 and any of these holds, including the md_wb cycle:
- md_rd matches rs1_d or rs2_d (RAW);
- regwrite_d and rd_d==md_rd (WAW).
REQ-025 SHALL raise a structural stall when md_op_d holds while busy and cnt!=0.
REQ-026 SHALL drive stall_f, stall_d and flush_e all equal to the OR of the load-use, branch, scoreboard and structural stalls.
REQ-027 SHALL drive flush_d = branch_taken_d AND NOT stall_d.
REQ-028 SHALL compute all outputs other than scoreboard state combinationally from inputs, with no latency.

Reset
REQ-029 SHALL, when rst is sampled high, set busy=0, cnt=0 and md_rd=0, so md_busy=0 and md_wb=0 in the following cycle.
REQ-030 SHALL, on reset during an operation, abort that operation, never emit md_wb for it, and release scoreboard stalls.
REQ-031 SHALL give rst priority over a simultaneous md_start_e.

Verification
REQ-032 SHALL cover forwarding priority:
- rs1_e=5, rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1 -> fwd_a_e=10;
- then regwrite_m=0 -> fwd_a_e=01;
- rs1_e=0 -> fwd_a_e=00.
REQ-033 SHALL cover load-use: memtoreg_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1; with rd_e=0 -> all three 0.
REQ-034 SHALL cover the MUL/DIV timeline with MD_CYCLES=4: md_start_e=1, rd_e=9 at cycle 0 -> md_busy high at cycles 1-4, md_wb high only at cycle 4; rs1_d=9 stalls through cycle 4 and is released at cycle 5.
REQ-035 SHALL cover back-to-back starts with MD_CYCLES=4: md_op_d at cycle 2 -> stall; second md_start_e at cycle 4 (md_wb cycle) -> reload, md_wb again at cycle 8, no idle cycle between.
REQ-036 SHALL cover reset mid-operation: rst=1 at cycle 2 of a MD_CYCLES=4 operation -> md_busy=0 and md_rd=0 from cycle 3, no md_wb, stalls deassert.
REQ-037 SHALL cover the branch case: branch_d=1, regwrite_e=1, rd_e=3, rs1_d=3, branch_taken_d=1 -> stall=1 and flush_d=0; next cycle with no match -> flush_d=1.
